// File: rtl/cardinal_nic_pkg.sv
// cardinal_nic_pkg: shared widths, register-window addresses and
// status-bit position for the cardinal NIC.
package cardinal_nic_pkg;

  // Default packet / processor data width and virtual-channel bit position.
  // Buses are declared [0:W-1], so bit 0 is the MSB.
  localparam int NIC_DATA_W = 64;
  localparam int NIC_VC_BIT = 0;

  // Status words carry their full flag in the last (least significant) bit.
  localparam int NIC_STAT_BIT = NIC_DATA_W - 1;

  // Processor register window.
  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/cardinal_nic_channel_buf.sv
// nic_channel_buf: a one-entry packet buffer with a full flag.
// The owner guarantees load and clear are never asserted together
// (load only when empty, clear only when full).
module nic_channel_buf
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_W = NIC_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [0:DATA_W-1] load_data,
  input  logic              clear,
  output logic [0:DATA_W-1] data,
  output logic              full
);

  logic [0:DATA_W-1] data_q, data_d;
  logic              full_q, full_d;

  // Next-state: a load captures the packet and sets full; a clear only
  // drops the flag, leaving the stale data visible for later reads.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = load_data;
      full_d = 1'b1;
    end else if (clear) begin
      full_d = 1'b0;
    end
  end

  // Buffer registers, synchronously cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data = data_q;
  assign full = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// cardinal_nic: processor-facing register window plus one-entry
// injection/ejection channels toward the ring router.
// Optional feature: define CARDINAL_NIC_POLARITY_CHECK_EN to only inject a
// packet when its VC bit matches the router's current polarity phase.
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_W = NIC_DATA_W,
  parameter int VC_BIT = NIC_VC_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di
);

  localparam int STAT_BIT = DATA_W - 1;

  logic              rd_en;
  logic              wr_en;
  logic              in_load;
  logic              in_clear;
  logic              in_full;
  logic [0:DATA_W-1] in_buf;
  logic              out_load;
  logic              out_clear;
  logic              out_full;
  logic [0:DATA_W-1] out_buf;
  logic              gate;
  logic [0:DATA_W-1] in_stat;
  logic [0:DATA_W-1] out_stat;
  logic [0:DATA_W-1] d_out_q, d_out_d;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn & nicWrEn;

`ifdef CARDINAL_NIC_POLARITY_CHECK_EN
  // Inject only during the router phase that matches the packet's VC.
  always_comb begin
    gate = (out_buf[VC_BIT] == net_polarity);
  end
`else
  logic unused_polarity;

  // Polarity is irrelevant in this build; any phase may inject.
  always_comb begin
    gate            = 1'b1;
    unused_polarity = net_polarity;
  end
`endif

  // Router-side handshakes: both depend only on registered flags and the
  // router's own ready/phase signals, and are forced low during reset so
  // no handshake can complete in a reset cycle.
  always_comb begin
    net_so = out_full & net_ro & gate & ~reset;
    net_ri = ~in_full & ~reset;
  end

  // Channel buffer controls. A processor write to the output buffer is
  // decided on the pre-edge flag, so it is dropped even if the held packet
  // leaves at the same edge. Reading the input buffer frees it only when
  // it actually holds a packet.
  always_comb begin
    out_load  = wr_en & (addr == NIC_ADDR_OUT_BUF) & ~out_full;
    out_clear = net_so;
    in_load   = net_si & net_ri;
    in_clear  = rd_en & (addr == NIC_ADDR_IN_BUF) & in_full;
  end

  nic_channel_buf #(.DATA_W(DATA_W)) u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (in_load),
    .load_data (net_di),
    .clear     (in_clear),
    .data      (in_buf),
    .full      (in_full)
  );

  nic_channel_buf #(.DATA_W(DATA_W)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .load_data (d_in),
    .clear     (out_clear),
    .data      (out_buf),
    .full      (out_full)
  );

  assign net_do = out_buf;

  // Status words: all zeros except the flag in the last bit position.
  always_comb begin
    in_stat            = '0;
    out_stat           = '0;
    in_stat[STAT_BIT]  = in_full;
    out_stat[STAT_BIT] = out_full;
  end

  // Read mux for the processor window; d_out holds its value between reads.
  always_comb begin
    d_out_d = d_out_q;
    if (rd_en) begin
      case (addr)
        NIC_ADDR_IN_BUF:   d_out_d = in_buf;
        NIC_ADDR_IN_STAT:  d_out_d = in_stat;
        NIC_ADDR_OUT_BUF:  d_out_d = '0;
        NIC_ADDR_OUT_STAT: d_out_d = out_stat;
        default:           d_out_d = '0;
      endcase
    end
  end

  // Registered processor read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q <= '0;
    end else begin
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_cardinal_nic.sv
// tb_cardinal_nic: randomized and directed bench for cardinal_nic with a
// queue-based behavioural model and a per-cycle compare process.
module tb_cardinal_nic;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;

  int passCount = 0;
  int checkCount = 0;
  bit checkEn = 0;

  // Behavioural model: each channel is a queue holding at most one packet.
  logic [63:0] inQ[$];
  logic [63:0] outQ[$];
  logic [63:0] inLast = '0;
  logic [63:0] mDout = '0;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di)
  );

  // Free-running clock.
  initial clk = 0;
  always #5 clk = ~clk;

  function automatic bit expGate();
`ifdef CARDINAL_NIC_POLARITY_CHECK_EN
    // VC bit is bit 0 of a [0:63] bus, i.e. the numeric MSB.
    if (outQ.size() == 0) return 1'b0;
    return outQ[0][63] == net_polarity;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit expSo();
    return !reset && outQ.size() == 1 && net_ro && expGate();
  endfunction

  function automatic bit expRi();
    return !reset && inQ.size() == 0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passCount++;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelEdge();
    bit rd, wr, soPre, riPre, inFullPre, outFullPre;
    if (reset) begin
      inQ.delete();
      outQ.delete();
      inLast = '0;
      mDout  = '0;
      return;
    end
    rd = nicEn && !nicWrEn;
    wr = nicEn && nicWrEn;
    soPre = expSo();
    riPre = expRi();
    inFullPre  = inQ.size() != 0;
    outFullPre = outQ.size() != 0;
    if (rd) begin
      case (addr)
        2'd0: begin
          mDout = inLast;
          if (inFullPre) void'(inQ.pop_front());
        end
        2'd1: mDout = 64'(inFullPre);
        2'd2: mDout = 64'd0;
        default: mDout = 64'(outFullPre);
      endcase
    end
    if (soPre) void'(outQ.pop_front());
    if (wr && addr == 2'd2 && !outFullPre) outQ.push_back(d_in);
    if (net_si && riPre) begin
      inQ.push_back(net_di);
      inLast = net_di;
    end
  endtask

  // Wait for the next edge, update the model, then present the next inputs
  // and return at the falling edge where this cycle's outputs are settled.
  task automatic applyStimulus(input bit rst, input bit en, input bit we, input logic [1:0] a,
                               input logic [63:0] din, input bit ro, input bit pol,
                               input bit si, input logic [63:0] di);
    @(posedge clk);
    modelEdge();
    #1;
    reset = rst; nicEn = en; nicWrEn = we; addr = a; d_in = din;
    net_ro = ro; net_polarity = pol; net_si = si; net_di = di;
    @(negedge clk);
  endtask

  task automatic idle(input bit ro, input bit pol);
    applyStimulus(0, 0, 0, 2'd0, 64'd0, ro, pol, 0, 64'd0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model net_so", 64'(net_so), 64'(expSo()));
      checkOutput("model net_ri", 64'(net_ri), 64'(expRi()));
      checkOutput("model d_out", d_out, mDout);
      if (expSo()) checkOutput("model net_do", net_do, outQ[0]);
    end
  end

  initial begin
    bit soExp;
    reset = 1; nicEn = 0; nicWrEn = 0; addr = 0; d_in = 0;
    net_ro = 0; net_polarity = 0; net_si = 0; net_di = 0;

    applyStimulus(1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    checkEn = 1;
    applyStimulus(1, 0, 0, 2'd0, 0, 1, 0, 1, 64'hdead);
    checkOutput("reset net_ri", 64'(net_ri), 64'd0);
    checkOutput("reset d_out", d_out, 64'd0);

    // Post-reset status reads.
    applyStimulus(0, 1, 0, 2'd1, 0, 0, 0, 0, 0);
    checkOutput("post-reset net_ri", 64'(net_ri), 64'd1);
    checkOutput("post-reset net_so", 64'(net_so), 64'd0);
    applyStimulus(0, 1, 0, 2'd3, 0, 0, 0, 0, 0);
    checkOutput("in status after reset", d_out, 64'd0);
    idle(0, 0);
    checkOutput("out status after reset", d_out, 64'd0);

    // Injection of a VC=1 packet in a matching phase.
    applyStimulus(0, 1, 1, 2'd2, 64'h8000_0000_0000_00AA, 1, 1, 0, 0);
    checkOutput("inject same-cycle net_so", 64'(net_so), 64'd0);
    idle(1, 1);
    checkOutput("inject net_so", 64'(net_so), 64'd1);
    checkOutput("inject net_do", net_do, 64'h8000_0000_0000_00AA);
    applyStimulus(0, 1, 0, 2'd3, 0, 1, 1, 0, 0);
    checkOutput("inject done net_so", 64'(net_so), 64'd0);
    idle(0, 0);
    checkOutput("out status after inject", d_out, 64'd0);

    // Ejection and readout.
    applyStimulus(0, 0, 0, 2'd0, 0, 0, 0, 1, 64'h1234);
    checkOutput("eject net_ri before", 64'(net_ri), 64'd1);
    applyStimulus(0, 1, 0, 2'd1, 0, 0, 0, 0, 0);
    checkOutput("eject net_ri full", 64'(net_ri), 64'd0);
    applyStimulus(0, 1, 0, 2'd0, 0, 0, 0, 0, 0);
    checkOutput("in status full", d_out, 64'd1);
    idle(0, 0);
    checkOutput("in buffer read", d_out, 64'h1234);
    checkOutput("eject net_ri freed", 64'(net_ri), 64'd1);

    // Second write while full is dropped.
    applyStimulus(0, 1, 1, 2'd2, 64'h11, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 2'd2, 64'h22, 0, 0, 0, 0);
    idle(1, 0);
    checkOutput("dropped write net_so", 64'(net_so), 64'd1);
    checkOutput("dropped write net_do", net_do, 64'h11);
    idle(0, 0);

    // Polarity gating of a VC=1 packet.
    applyStimulus(0, 1, 1, 2'd2, 64'h8000_0000_0000_0001, 1, 0, 0, 0);
    idle(1, 0);
`ifdef CARDINAL_NIC_POLARITY_CHECK_EN
    soExp = 0;
`else
    soExp = 1;
`endif
    checkOutput("polarity mismatch net_so", 64'(net_so), 64'(soExp));
    idle(1, 1);
    checkOutput("polarity match net_so", 64'(net_so), 64'(!soExp));
    idle(0, 0);

    // Reset with both channels holding packets.
    applyStimulus(0, 1, 1, 2'd2, 64'h77, 0, 0, 1, 64'h55);
    idle(0, 0);
    checkOutput("both full net_ri", 64'(net_ri), 64'd0);
    applyStimulus(1, 0, 0, 2'd0, 0, 1, 0, 0, 0);
    checkOutput("reset mid net_so", 64'(net_so), 64'd0);
    checkOutput("reset mid net_ri", 64'(net_ri), 64'd0);
    applyStimulus(1, 0, 0, 2'd0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 2'd1, 0, 1, 0, 0, 0);
    checkOutput("after reset out flag", 64'(net_so), 64'd0);
    checkOutput("after reset d_out", d_out, 64'd0);
    applyStimulus(0, 1, 0, 2'd3, 0, 1, 0, 0, 0);
    checkOutput("after reset in status", d_out, 64'd0);
    idle(0, 0);
    checkOutput("after reset out status", d_out, 64'd0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 1) == 1,
                    2'($urandom_range(0, 3)),
                    {$urandom, $urandom},
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1,
                    {$urandom, $urandom});
    end

    checkEn = 0;
    @(posedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
